instruction_fetcher: RTL and testbench

INSTRUCTION_FETCHER -- requirements
Module: instruction_fetcher

---
 rtl/core_pkg.sv | 24 ++
 rtl/instruction_fetcher_if.sv | 12 +
 rtl/fetch_cache_entry.sv | 43 ++++
 rtl/instruction_fetcher.sv | 134 +++++++++++++
 tb/tb_instruction_fetcher.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared types and constants for the instruction fetcher
// Contents: fetch_state_t FSM encoding, register-field bit positions,
//           the NOP word returned on an aborted fetch, and a field-extract helper.
package core_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } fetch_state_t;

    localparam int REG_W       = 5;
    localparam int OUT_REG_LSB = 21;
    localparam int IN0_REG_LSB = 16;
    localparam int IN1_REG_LSB = 11;
    localparam int IN2_REG_LSB = 6;

    localparam logic [31:0] NOP_WORD = 32'h0;

    function automatic logic [REG_W-1:0] reg_field(input logic [31:0] word, input int lsb);
        return word[lsb +: REG_W];
    endfunction

endpackage

// File: rtl/instruction_fetcher_if.sv
// rtl/instruction_fetcher_if.sv - memory read bus between fetcher and instruction memory
// Signals: mem_req/mem_addr (fetcher -> memory), mem_ack/mem_rdata (memory -> fetcher).
// Modports: master = fetcher side, slave = memory side.
interface instruction_fetcher_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/fetch_cache_entry.sv
// rtl/fetch_cache_entry.sv - single-entry instruction cache (tag + valid + data)
// Ports: clk, reset (sync, active-high); i_fill/i_fill_tag/i_fill_data write the entry;
//        i_inv clears valid (wins over a simultaneous fill); i_lookup_tag -> o_hit, o_data.
module fetch_cache_entry
    import core_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_fill,
    input  logic        i_inv,
    input  logic [29:0] i_fill_tag,
    input  logic [31:0] i_fill_data,
    input  logic [29:0] i_lookup_tag,
    output logic        o_hit,
    output logic [31:0] o_data
);

    logic        r_valid;
    logic [29:0] r_tag;
    logic [31:0] r_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_data  <= NOP_WORD;
        end else begin
            if (i_fill) begin
                r_tag  <= i_fill_tag;
                r_data <= i_fill_data;
            end
            if (i_inv) begin
                r_valid <= 1'b0;
            end else if (i_fill) begin
                r_valid <= 1'b1;
            end
        end
    end

    assign o_hit  = r_valid && (r_tag == i_lookup_tag);
    assign o_data = r_data;

endmodule

// File: rtl/instruction_fetcher.sv
// rtl/instruction_fetcher.sv - single-word instruction fetch FSM with timeout and decode
// Ports: clk, reset (sync, active-high); mem (instruction_fetcher_if.master);
//        i_fetcher_reset (high = hold idle), i_pc; o_fetcher_completed, o_instr,
//        o_in_reg_num[3], o_out_reg_num, o_fetch_timeout; i_cache_inv (FETCH_CACHE_EN only).
// Build option: define FETCH_CACHE_EN for a one-entry instruction cache.
module instruction_fetcher
    import core_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    instruction_fetcher_if.master  mem,
    input  logic                   i_fetcher_reset,
    input  logic [31:0]            i_pc,
    output logic                   o_fetcher_completed,
    output logic [31:0]            o_instr,
    output logic [2:0][REG_W-1:0]  o_in_reg_num,
    output logic [REG_W-1:0]       o_out_reg_num,
    output logic                   o_fetch_timeout
`ifdef FETCH_CACHE_EN
    ,
    input  logic                   i_cache_inv
`endif
);

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    fetch_state_t r_state;
    fetch_state_t w_next_state;
    logic [31:0]  r_instr;
    logic [31:0]  w_next_instr;
    logic         r_fetch_timeout;
    logic         w_next_timeout;
    logic [15:0]  r_wait_cnt;
    logic [15:0]  w_next_cnt;

    logic         w_cache_hit;
    logic [31:0]  w_cache_data;

    // Byte offset within the word is irrelevant to a word fetch.
    logic         w_unused_pc_bits;
    assign w_unused_pc_bits = ^i_pc[1:0];

`ifdef FETCH_CACHE_EN
    logic w_fill;
    // Only a real ack fills; a fetcher_reset in the ack cycle discards the data.
    assign w_fill = (r_state == ST_REQ) && !i_fetcher_reset && mem.mem_ack;

    fetch_cache_entry u_cache (
        .clk          (clk),
        .reset        (reset),
        .i_fill       (w_fill),
        .i_inv        (i_cache_inv),
        .i_fill_tag   (i_pc[31:2]),
        .i_fill_data  (mem.mem_rdata),
        .i_lookup_tag (i_pc[31:2]),
        .o_hit        (w_cache_hit),
        .o_data       (w_cache_data)
    );
`else
    assign w_cache_hit  = 1'b0;
    assign w_cache_data = NOP_WORD;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_instr         <= NOP_WORD;
            r_fetch_timeout <= 1'b0;
            r_wait_cnt      <= '0;
        end else begin
            r_state         <= w_next_state;
            r_instr         <= w_next_instr;
            r_fetch_timeout <= w_next_timeout;
            r_wait_cnt      <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_next_instr   = r_instr;
        w_next_timeout = r_fetch_timeout;
        w_next_cnt     = r_wait_cnt;
        case (r_state)
            ST_IDLE: begin
                if (!i_fetcher_reset) begin
                    if (w_cache_hit) begin
                        w_next_state   = ST_DONE;
                        w_next_instr   = w_cache_data;
                        w_next_timeout = 1'b0;
                    end else begin
                        w_next_state = ST_REQ;
                        w_next_cnt   = '0;
                    end
                end
            end
            ST_REQ: begin
                if (i_fetcher_reset) begin
                    w_next_state = ST_IDLE;
                end else if (mem.mem_ack) begin
                    w_next_state   = ST_DONE;
                    w_next_instr   = mem.mem_rdata;
                    w_next_timeout = 1'b0;
                end else if (r_wait_cnt == TIMEOUT_LAST) begin
                    w_next_state   = ST_DONE;
                    w_next_instr   = NOP_WORD;
                    w_next_timeout = 1'b1;
                end else begin
                    w_next_cnt = r_wait_cnt + 16'd1;
                end
            end
            ST_DONE: begin
                if (i_fetcher_reset) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign mem.mem_req          = (r_state == ST_REQ);
    assign mem.mem_addr         = {i_pc[31:2], 2'b00};
    assign o_fetcher_completed  = (r_state == ST_DONE);
    assign o_instr              = r_instr;
    assign o_fetch_timeout      = r_fetch_timeout;
    assign o_out_reg_num        = reg_field(r_instr, OUT_REG_LSB);
    assign o_in_reg_num[0]      = reg_field(r_instr, IN0_REG_LSB);
    assign o_in_reg_num[1]      = reg_field(r_instr, IN1_REG_LSB);
    assign o_in_reg_num[2]      = reg_field(r_instr, IN2_REG_LSB);

endmodule

// File: tb/tb_instruction_fetcher.sv
// tb/tb_instruction_fetcher.sv - self-checking bench for instruction_fetcher
module tb_instruction_fetcher;

`ifdef FETCH_CACHE_EN
    localparam bit HAS_CACHE = 1'b1;
`else
    localparam bit HAS_CACHE = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        sel = 1'b0;
    logic        drv_fr = 1'b1;
    logic [31:0] drv_pc = 32'h0;
    logic        drv_ack = 1'b0;
    logic [31:0] drv_rdata = 32'h0;
`ifdef FETCH_CACHE_EN
    logic        cache_inv = 1'b0;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    instruction_fetcher_if m_if ();
    instruction_fetcher_if t_if ();

    logic        m_fr, t_fr;
    logic        m_done, t_done, m_tmo, t_tmo;
    logic [31:0] m_instr, t_instr;
    logic [2:0][4:0] m_in, t_in;
    logic [4:0]  m_out, t_out;

    assign m_fr = sel ? 1'b1 : drv_fr;
    assign t_fr = sel ? drv_fr : 1'b1;
    assign m_if.mem_ack   = sel ? 1'b0 : drv_ack;
    assign t_if.mem_ack   = sel ? drv_ack : 1'b0;
    assign m_if.mem_rdata = drv_rdata;
    assign t_if.mem_rdata = drv_rdata;

    instruction_fetcher dut (
        .clk                 (clk),
        .reset               (reset),
        .mem                 (m_if.master),
        .i_fetcher_reset     (m_fr),
        .i_pc                (drv_pc),
        .o_fetcher_completed (m_done),
        .o_instr             (m_instr),
        .o_in_reg_num        (m_in),
        .o_out_reg_num       (m_out),
        .o_fetch_timeout     (m_tmo)
`ifdef FETCH_CACHE_EN
        ,
        .i_cache_inv         (cache_inv)
`endif
    );

    instruction_fetcher #(.TIMEOUT_CYCLES(4)) dut_t (
        .clk                 (clk),
        .reset               (reset),
        .mem                 (t_if.master),
        .i_fetcher_reset     (t_fr),
        .i_pc                (drv_pc),
        .o_fetcher_completed (t_done),
        .o_instr             (t_instr),
        .o_in_reg_num        (t_in),
        .o_out_reg_num       (t_out),
        .o_fetch_timeout     (t_tmo)
`ifdef FETCH_CACHE_EN
        ,
        .i_cache_inv         (cache_inv)
`endif
    );

    logic        obs_done, obs_req, obs_tmo;
    logic [31:0] obs_addr, obs_instr;
    assign obs_done  = sel ? t_done : m_done;
    assign obs_req   = sel ? t_if.mem_req : m_if.mem_req;
    assign obs_addr  = sel ? t_if.mem_addr : m_if.mem_addr;
    assign obs_tmo   = sel ? t_tmo : m_tmo;
    assign obs_instr = sel ? t_instr : m_instr;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rdata;
        int          delay;
        logic [31:0] addr;
        logic [4:0]  out_r;
        logic [4:0]  in0;
        logic [4:0]  in1;
        logic [4:0]  in2;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Starts a fetch at a negedge and serves it; ack is given on REQ cycle delay+1.
    task automatic run_fetch(input logic [31:0] pc, input logic [31:0] rdata, input int delay,
                             input logic [31:0] exp_addr, output int lat, output int reqc,
                             output bit addr_ok, output bit done);
        @(negedge clk);
        drv_pc = pc; drv_fr = 1'b0; drv_ack = 1'b0; drv_rdata = 32'hDEADBEEF;
        lat = 0; reqc = 0; addr_ok = 1'b1; done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            lat++;
            if (obs_done) begin
                done = 1'b1;
            end else if (obs_req) begin
                reqc++;
                if (obs_addr !== exp_addr) addr_ok = 1'b0;
                drv_ack   = (reqc - 1 == delay);
                drv_rdata = drv_ack ? rdata : 32'hDEADBEEF;
            end else begin
                drv_ack = 1'b0;
            end
        end
        drv_ack = 1'b0;
    endtask

    task automatic release_fetch();
        drv_fr = 1'b1;
        @(negedge clk);
        chk("release_completed", {31'b0, obs_done}, 32'd0);
    endtask

    int lat, reqc;
    bit addr_ok, done;

    initial begin
        vecs[0] = '{32'h0000_0104, 32'h0443_1880, 0, 32'h0000_0104, 5'd2,  5'd3,  5'd3,  5'd2};
        vecs[1] = '{32'h1000_0203, 32'hFFFF_FFFF, 1, 32'h1000_0200, 5'd31, 5'd31, 5'd31, 5'd31};
        vecs[2] = '{32'h0000_0800, 32'h03E0_0000, 5, 32'h0000_0800, 5'd31, 5'd0,  5'd0,  5'd0};
        vecs[3] = '{32'h0000_0C01, 32'h001F_0000, 2, 32'h0000_0C00, 5'd0,  5'd31, 5'd0,  5'd0};
        vecs[4] = '{32'hFFFF_FFFE, 32'h0000_F800, 3, 32'hFFFF_FFFC, 5'd0,  5'd0,  5'd31, 5'd0};
        vecs[5] = '{32'h0000_1002, 32'hFC00_07FF, 4, 32'h0000_1000, 5'd0,  5'd0,  5'd0,  5'd31};

        repeat (3) @(negedge clk);
        chk("rst_completed", {31'b0, m_done}, 32'd0);
        chk("rst_mem_req", {31'b0, m_if.mem_req}, 32'd0);
        chk("rst_instr", m_instr, 32'h0);
        chk("rst_timeout", {31'b0, m_tmo}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            run_fetch(vecs[v].pc, vecs[v].rdata, vecs[v].delay, vecs[v].addr, lat, reqc, addr_ok, done);
            chk($sformatf("v%0d_done", v), {31'b0, done}, 32'd1);
            chk($sformatf("v%0d_latency", v), lat, 32'(2 + vecs[v].delay));
            chk($sformatf("v%0d_req_cycles", v), reqc, 32'(vecs[v].delay + 1));
            chk($sformatf("v%0d_addr", v), {31'b0, addr_ok}, 32'd1);
            chk($sformatf("v%0d_instr", v), m_instr, vecs[v].rdata);
            chk($sformatf("v%0d_out_reg", v), {27'b0, m_out}, {27'b0, vecs[v].out_r});
            chk($sformatf("v%0d_in0", v), {27'b0, m_in[0]}, {27'b0, vecs[v].in0});
            chk($sformatf("v%0d_in1", v), {27'b0, m_in[1]}, {27'b0, vecs[v].in1});
            chk($sformatf("v%0d_in2", v), {27'b0, m_in[2]}, {27'b0, vecs[v].in2});
            chk($sformatf("v%0d_timeout", v), {31'b0, m_tmo}, 32'd0);
            @(negedge clk);
            chk($sformatf("v%0d_hold", v), {31'b0, m_done}, 32'd1);
            chk($sformatf("v%0d_req_in_done", v), {31'b0, m_if.mem_req}, 32'd0);
            release_fetch();
        end

        // fetcher_reset raised together with ack on the 2nd REQ cycle
        @(negedge clk);
        drv_pc = 32'h0000_0400; drv_fr = 1'b0; drv_ack = 1'b0;
        @(negedge clk);
        chk("abort_req1", {31'b0, m_if.mem_req}, 32'd1);
        @(negedge clk);
        chk("abort_req2", {31'b0, m_if.mem_req}, 32'd1);
        drv_fr = 1'b1; drv_ack = 1'b1; drv_rdata = 32'h5555_AAAA;
        @(negedge clk);
        drv_ack = 1'b0;
        chk("abort_completed", {31'b0, m_done}, 32'd0);
        chk("abort_mem_req", {31'b0, m_if.mem_req}, 32'd0);
        chk("abort_instr", m_instr, 32'hFC00_07FF);
        @(negedge clk);
        chk("abort_completed_later", {31'b0, m_done}, 32'd0);

        // reset beats an ack during REQ
        drv_pc = 32'h0000_0500; drv_fr = 1'b0;
        @(negedge clk);
        chk("rstreq_req", {31'b0, m_if.mem_req}, 32'd1);
        reset = 1'b1; drv_ack = 1'b1; drv_rdata = 32'h0000_0077;
        @(negedge clk);
        chk("rstreq_completed", {31'b0, m_done}, 32'd0);
        chk("rstreq_mem_req", {31'b0, m_if.mem_req}, 32'd0);
        chk("rstreq_instr", m_instr, 32'h0);
        reset = 1'b0; drv_ack = 1'b0; drv_fr = 1'b1;
        @(negedge clk);

        // Repeated fetch of 0x200: hits when the cache is built in
        run_fetch(32'h0000_0200, 32'h1234_5678, 0, 32'h0000_0200, lat, reqc, addr_ok, done);
        chk("c1_req_cycles", reqc, 32'd1);
        chk("c1_instr", m_instr, 32'h1234_5678);
        release_fetch();
        run_fetch(32'h0000_0200, 32'h9999_0000, 0, 32'h0000_0200, lat, reqc, addr_ok, done);
        chk("c2_latency", lat, HAS_CACHE ? 32'd1 : 32'd2);
        chk("c2_req_cycles", reqc, HAS_CACHE ? 32'd0 : 32'd1);
        chk("c2_instr", m_instr, HAS_CACHE ? 32'h1234_5678 : 32'h9999_0000);
        release_fetch();
`ifdef FETCH_CACHE_EN
        run_fetch(32'h0000_0202, 32'h9999_0000, 0, 32'h0000_0200, lat, reqc, addr_ok, done);
        chk("c3_offset_hit_req", reqc, 32'd0);
        chk("c3_offset_hit_instr", m_instr, 32'h1234_5678);
        release_fetch();
        cache_inv = 1'b1;
        @(negedge clk);
        cache_inv = 1'b0;
        run_fetch(32'h0000_0200, 32'h0BAD_F00D, 0, 32'h0000_0200, lat, reqc, addr_ok, done);
        chk("c4_after_inv_req", reqc, 32'd1);
        chk("c4_after_inv_instr", m_instr, 32'h0BAD_F00D);
        release_fetch();
        // invalidate in the fill cycle leaves the entry invalid
        @(negedge clk);
        drv_pc = 32'h0000_0300; drv_fr = 1'b0;
        @(negedge clk);
        drv_ack = 1'b1; drv_rdata = 32'h3333_0000; cache_inv = 1'b1;
        @(negedge clk);
        drv_ack = 1'b0; cache_inv = 1'b0;
        chk("c5_instr", m_instr, 32'h3333_0000);
        release_fetch();
        run_fetch(32'h0000_0300, 32'h3333_0001, 0, 32'h0000_0300, lat, reqc, addr_ok, done);
        chk("c5_inv_wins_req", reqc, 32'd1);
        release_fetch();
        run_fetch(32'h0000_0200, 32'h0BAD_F00D, 0, 32'h0000_0200, lat, reqc, addr_ok, done);
        release_fetch();
`endif

        // reset while in DONE, then refetch the same pc
        run_fetch(32'h0000_0200, 32'h0BAD_F00D, 0, 32'h0000_0200, lat, reqc, addr_ok, done);
        chk("rd_done", {31'b0, done}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("rd_completed", {31'b0, m_done}, 32'd0);
        chk("rd_instr", m_instr, 32'h0);
        reset = 1'b0; drv_fr = 1'b1;
        @(negedge clk);
        run_fetch(32'h0000_0200, 32'h0BAD_F00D, 0, 32'h0000_0200, lat, reqc, addr_ok, done);
        chk("rd_refetch_miss", reqc, 32'd1);
        release_fetch();

        // TIMEOUT_CYCLES=4 instance
        sel = 1'b1;
        @(negedge clk);
        run_fetch(32'h0000_0600, 32'hABCD_1234, 0, 32'h0000_0600, lat, reqc, addr_ok, done);
        chk("t1_instr", t_instr, 32'hABCD_1234);
        release_fetch();
        run_fetch(32'h0000_0604, 32'h1111_1111, 1000, 32'h0000_0604, lat, reqc, addr_ok, done);
        chk("t2_done", {31'b0, done}, 32'd1);
        chk("t2_req_cycles", reqc, 32'd4);
        chk("t2_latency", lat, 32'd5);
        chk("t2_timeout", {31'b0, t_tmo}, 32'd1);
        chk("t2_instr", t_instr, 32'h0);
        release_fetch();
        run_fetch(32'h0000_0608, 32'h2222_0000, 3, 32'h0000_0608, lat, reqc, addr_ok, done);
        chk("t3_last_cycle_ack_instr", t_instr, 32'h2222_0000);
        chk("t3_timeout", {31'b0, t_tmo}, 32'd0);
        release_fetch();
        run_fetch(32'h0000_0604, 32'h4444_0000, 0, 32'h0000_0604, lat, reqc, addr_ok, done);
        chk("t4_no_fill_on_timeout", reqc, 32'd1);
        chk("t4_instr", t_instr, 32'h4444_0000);
        release_fetch();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
